// File: rtl/regfile_pkg.sv
// Shared widths, state encoding and the power-on init pattern for the
// register-file write-back arbiter.
package regfile_pkg;

  localparam int DATA_W       = 32;
  localparam int N_REGS       = 16;
  localparam int REG_AW       = $clog2(N_REGS);
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Each register is initialised with its own index.
  function automatic logic [DATA_W-1:0] init_pattern(input logic [REG_AW-1:0] idx);
    return {{(DATA_W-REG_AW){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/wb_grant_logic.sv
// Two-requester grant for the write-back port: P wins by default, A wins
// once it has been stalled MAX_WAIT consecutive cycles.
module wb_grant_logic
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic p_valid,
  input  logic a_valid,
  output logic p_grant,
  output logic a_grant
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              starved;

  assign starved = (wait_cnt == WAIT_W'(MAX_WAIT));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_grant = 1'b0;
    p_grant = 1'b0;
    if (run) begin
      a_grant = a_valid && (!p_valid || starved);
      p_grant = p_valid && !a_grant;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!a_valid || a_grant) begin
      wait_cnt <= '0;
    end else if (run && !starved) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: power-on init of every register with its
// index, then arbitration between the WB stage (P) and the aux unit (A).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  input  logic [REG_AW-1:0] p_dest,
  input  logic [DATA_W-1:0] p_data,
  output logic              p_ready,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              init_done
);

  state_t            state, state_next;
  logic [REG_AW-1:0] idx;
  logic              run;
  logic              p_grant, a_grant;

  wb_grant_logic #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .p_valid (p_valid),
    .a_valid (a_valid),
    .p_grant (p_grant),
    .a_grant (a_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && idx == REG_AW'(N_REGS - 1)) state_next = RUN;
  end

  always_comb begin
    run       = (state == RUN);
    init_done = run;
    p_ready   = p_grant;
    a_ready   = a_grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx <= '0;
    else if (state == INIT) idx <= idx + REG_AW'(1);
  end

  // NOTE: only control/datapath flops are reset here; the register array itself lives outside and is filled by the init sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
    end else if (state == INIT) begin
      wb_en   <= 1'b1;
      wb_dest <= idx;
      wb_data <= init_pattern(idx);
    end else if (a_grant) begin
      wb_en   <= 1'b1;
      wb_dest <= a_dest;
      wb_data <= a_data;
    end else if (p_grant) begin
      wb_en   <= 1'b1;
      wb_dest <= p_dest;
      wb_data <= p_data;
    end else begin
      // Idle: address/data hold their last values.
      wb_en <= 1'b0;
    end
  end

endmodule
